// File: rtl/burst_mem_pkg.sv
// Shared types and geometry for the 4-beat x 64-bit burst memory responder.
package burst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BEATS    = 4;
  localparam int BEAT_W   = 64;
  localparam int LINE_W   = BEATS * BEAT_W;
  localparam int OFFSET_W = 5;

endpackage

// File: rtl/burst_mem_responder_if.sv
// Physical-memory burst bus between the cache line adaptor (master) and the responder (slave).
interface burst_mem_responder_if;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/burst_line_ram.sv
// Line store addressed per beat: {line index, beat}. Registered read port, one beat-write port.
module burst_line_ram
  import burst_mem_pkg::*;
#(
  parameter int LINE_IDX_W = 8,
  localparam int ADDR_W = LINE_IDX_W + $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [BEAT_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BEAT_W-1:0] wr_data
);

  logic [BEAT_W-1:0] store [2**ADDR_W];

  // Store contents deliberately survive reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (wr_en) store[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else if (rd_en) rd_data <= store[rd_addr];
  end

endmodule

// File: rtl/burst_mem_responder.sv
// Burst memory responder: accepts a line read/write, waits LATENCY cycles, then runs 4 beats.
//  state | meaning
//  IDLE  | no request; accept read/write, latch index and direction
//  WAIT  | latency down-counter running; request drop aborts
//  BURST | mem_resp high, one beat per cycle (beat_cnt 0..3)
//  DONE  | burst complete; wait for request to drop
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int LATENCY    = 10,
  parameter int LINE_IDX_W = 8,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  burst_mem_responder_if.slave bus,
  output logic                 proto_err,
  output logic [CNT_W-1:0]     read_count,
  output logic [CNT_W-1:0]     write_count
);

  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int ADDR_W = LINE_IDX_W + $clog2(BEATS);

  state_t                state;
  logic [LAT_W-1:0]      lat_cnt;
  logic [1:0]            beat_cnt;
  logic [LINE_IDX_W-1:0] idx;
  logic                  dir_read;
  logic                  resp_q;

  logic                  req;
  logic [1:0]            rd_beat;
  logic                  rd_en;
  logic                  wr_en;
  logic                  unused_addr;

  assign req         = bus.mem_read | bus.mem_write;
  assign unused_addr = ^{bus.mem_addr[31:LINE_IDX_W+OFFSET_W], bus.mem_addr[OFFSET_W-1:0]};

  // Read port runs one beat ahead so registered data lines up with mem_resp.
  assign rd_beat = (state == BURST) ? beat_cnt + 2'd1 : 2'd0;
  assign rd_en   = dir_read & (((state == WAIT) & (lat_cnt == '0)) |
                               ((state == BURST) & (beat_cnt != 2'd3)));
  assign wr_en   = (state == BURST) & ~dir_read & req;

  assign bus.mem_resp = resp_q;

  burst_line_ram #(.LINE_IDX_W(LINE_IDX_W)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .rd_addr ({idx, rd_beat}),
    .rd_data (bus.mem_rdata),
    .wr_en   (wr_en),
    .wr_addr ({idx, beat_cnt}),
    .wr_data (bus.mem_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      beat_cnt    <= '0;
      idx         <= '0;
      dir_read    <= 1'b0;
      resp_q      <= 1'b0;
      proto_err   <= 1'b0;
      read_count  <= '0;
      write_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx      <= bus.mem_addr[LINE_IDX_W+OFFSET_W-1:OFFSET_W];
            dir_read <= bus.mem_read;
            lat_cnt  <= LAT_W'(LATENCY - 1);
            state    <= WAIT;
            if (bus.mem_read & bus.mem_write) proto_err <= 1'b1;
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
          end else if (lat_cnt == '0) begin
            state    <= BURST;
            beat_cnt <= 2'd0;
            resp_q   <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        BURST: begin
          if (!req) begin
            state  <= IDLE;
            resp_q <= 1'b0;
          end else if (beat_cnt == 2'd3) begin
            state  <= DONE;
            resp_q <= 1'b0;
            if (dir_read) begin
              if (read_count != '1) read_count <= read_count + 1'b1;
            end else begin
              if (write_count != '1) write_count <= write_count + 1'b1;
            end
          end else begin
            beat_cnt <= beat_cnt + 2'd1;
          end
        end
        DONE: begin
          if (!req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
